// File: rtl/iiitb_brg_prog.sv
// Programmable baud-rate generator: preset or custom divisor, oversample tick,
// baud tick and 50% duty baud clock, divisor swaps only on baud boundaries.
module iiitb_brg_prog #(
    parameter int DIV_W = 16,
    parameter int OVS   = 16,
    parameter int DIV0  = 326,
    parameter int DIV1  = 163,
    parameter int DIV2  = 81,
    parameter int DIV3  = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             use_custom,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_ovs,
    output logic             tick_baud,
    output logic             clkout,
    output logic [DIV_W-1:0] div_active,
    output logic             upd_pend
);

    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] OMAX  = OW'(OVS - 1);
    localparam logic [OW-1:0] OHALF = OW'(OVS / 2 - 1);

    logic [DIV_W-1:0] custom;
    logic [DIV_W-1:0] preset;
    logic [DIV_W-1:0] req;
    logic [DIV_W-1:0] dlast;
    logic [DIV_W-1:0] pcnt;
    logic [OW-1:0]    ocnt;
    logic             pwrap;
    logic             owrap;

    always_comb begin
        preset = DIV_W'(DIV0);
        unique case (sel)
            2'b00: preset = DIV_W'(DIV0);
            2'b01: preset = DIV_W'(DIV1);
            2'b10: preset = DIV_W'(DIV2);
            2'b11: preset = DIV_W'(DIV3);
        endcase
    end

    // A zero divisor is treated as one so the prescaler never stalls.
    assign req   = use_custom ? custom : preset;
    assign dlast = (div_active == '0) ? '0 : div_active - DIV_W'(1);
    assign pwrap = (pcnt == dlast);
    assign owrap = (ocnt == OMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            custom   <= DIV_W'(DIV0);
            upd_pend <= 1'b0;
        end else begin
            if (div_load)
                custom <= div_in;
            upd_pend <= (req != div_active);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt       <= '0;
            ocnt       <= '0;
            tick_ovs   <= 1'b0;
            tick_baud  <= 1'b0;
            clkout     <= 1'b0;
            div_active <= DIV_W'(DIV0);
        end else if (!en) begin
            pcnt       <= '0;
            ocnt       <= '0;
            tick_ovs   <= 1'b0;
            tick_baud  <= 1'b0;
            clkout     <= 1'b0;
            div_active <= req;
        end else begin
            tick_ovs  <= pwrap;
            tick_baud <= pwrap && owrap;
            if (pwrap) begin
                pcnt <= '0;
                ocnt <= owrap ? '0 : ocnt + OW'(1);
                if (ocnt == OHALF)
                    clkout <= 1'b1;
                // Boundary: close the period and pick up the requested divisor.
                if (owrap) begin
                    clkout     <= 1'b0;
                    div_active <= req;
                end
            end else begin
                pcnt <= pcnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_iiitb_brg_prog.sv
// Directed bench for iiitb_brg_prog: table of divisor settings with
// measured periods, plus hand sequences for boundary and reset cases.
module tb_iiitb_brg_prog;

    localparam int LIM = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  sel;
    logic        use_custom;
    logic        div_load;
    logic [15:0] div_in;
    logic        tick_ovs;
    logic        tick_baud;
    logic        clkout;
    logic [15:0] div_active;
    logic        upd_pend;

    int cmp = 0;
    int mism = 0;

    iiitb_brg_prog dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sel        (sel),
        .use_custom (use_custom),
        .div_load   (div_load),
        .div_in     (div_in),
        .tick_ovs   (tick_ovs),
        .tick_baud  (tick_baud),
        .clkout     (clkout),
        .div_active (div_active),
        .upd_pend   (upd_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uc;
        logic [1:0]  s;
        logic [15:0] cdiv;
        int          exp_act;
        int          exp_d;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            mism++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return tick_ovs;
            1:       return tick_baud;
            default: return clkout;
        endcase
    endfunction

    // Steps until the selected output next equals val; n = steps taken.
    task automatic nxt(input int which, input logic val, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sig(which) !== val && n < LIM);
        if (sig(which) !== val) begin
            cmp++;
            mism++;
            $display("FAIL timeout waiting on output %0d: got %b expected %b",
                     which, sig(which), val);
            n = -1;
        end
    endtask

    initial begin
        int n;
        int d;
        reset      = 1'b0;
        en         = 1'b0;
        sel        = 2'b11;
        use_custom = 1'b0;
        div_load   = 1'b0;
        div_in     = '0;

        tbl[0] = '{1'b0, 2'b11, 16'd0, 27, 27};
        tbl[1] = '{1'b0, 2'b10, 16'd0, 81, 81};
        tbl[2] = '{1'b1, 2'b00, 16'd3, 3, 3};
        tbl[3] = '{1'b1, 2'b00, 16'd0, 0, 1};
        tbl[4] = '{1'b1, 2'b00, 16'd1, 1, 1};
        tbl[5] = '{1'b0, 2'b01, 16'd0, 163, 163};

        #12;
        chk("rst tick_ovs", int'(tick_ovs), 0);
        chk("rst tick_baud", int'(tick_baud), 0);
        chk("rst clkout", int'(clkout), 0);
        chk("rst upd_pend", int'(upd_pend), 0);
        chk("rst div_active", int'(div_active), 326);
        step();
        reset = 1'b1;
        step();

        foreach (tbl[i]) begin
            d = tbl[i].exp_d;
            en = 1'b0;
            sel = tbl[i].s;
            use_custom = tbl[i].uc;
            div_in = tbl[i].cdiv;
            div_load = tbl[i].uc;
            step();
            div_load = 1'b0;
            step();
            chk($sformatf("v%0d div_active", i), int'(div_active),
                tbl[i].exp_act);
            en = 1'b1;
            nxt(0, 1'b1, n);
            chk($sformatf("v%0d first ovs", i), n, d);
            nxt(0, 1'b1, n);
            chk($sformatf("v%0d ovs period", i), n, d);
            nxt(1, 1'b1, n);
            chk($sformatf("v%0d clkout at baud", i), int'(clkout), 0);
            nxt(1, 1'b1, n);
            chk($sformatf("v%0d baud period", i), n, d * 16);
            nxt(2, 1'b1, n);
            chk($sformatf("v%0d clkout low", i), n, d * 8);
            nxt(2, 1'b0, n);
            chk($sformatf("v%0d clkout high", i), n, d * 8);
            chk($sformatf("v%0d baud at fall", i), int'(tick_baud), 1);
        end

        // Preset change mid-period: old period completes, then 326*16.
        en = 1'b0;
        sel = 2'b11;
        use_custom = 1'b0;
        step();
        en = 1'b1;
        nxt(1, 1'b1, n);
        repeat (100) step();
        sel = 2'b00;
        step();
        chk("sel chg upd_pend", int'(upd_pend), 1);
        chk("sel chg hold", int'(div_active), 27);
        nxt(1, 1'b1, n);
        chk("sel chg old period", n, 432 - 101);
        chk("sel chg commit", int'(div_active), 326);
        step();
        chk("sel chg upd clr", int'(upd_pend), 0);
        nxt(1, 1'b1, n);
        chk("sel chg new period", n, 5216 - 1);

        // Custom load while running, then a load on the boundary edge.
        repeat (50) step();
        div_in = 16'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        use_custom = 1'b1;
        nxt(1, 1'b1, n);
        chk("cust commit", int'(div_active), 3);
        nxt(1, 1'b1, n);
        chk("cust baud", n, 48);
        nxt(0, 1'b1, n);
        chk("cust ovs", n, 3);
        nxt(1, 1'b1, n);
        repeat (47) step();
        div_in = 16'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("edge load baud", int'(tick_baud), 1);
        chk("edge load old R", int'(div_active), 3);
        nxt(1, 1'b1, n);
        chk("edge load period", n, 48);
        chk("edge load commit", int'(div_active), 5);
        nxt(1, 1'b1, n);
        chk("edge load new period", n, 80);

        // Enable dropped mid-period with a divisor change while idle.
        repeat (30) step();
        en = 1'b0;
        step();
        chk("idle tick_ovs", int'(tick_ovs), 0);
        chk("idle tick_baud", int'(tick_baud), 0);
        chk("idle clkout", int'(clkout), 0);
        use_custom = 1'b0;
        sel = 2'b10;
        step();
        chk("idle div_active", int'(div_active), 81);
        en = 1'b1;
        nxt(0, 1'b1, n);
        chk("reen first ovs", n, 81);

        // Async reset between edges, in the high half of clkout.
        nxt(2, 1'b1, n);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("areset clkout", int'(clkout), 0);
        chk("areset tick_ovs", int'(tick_ovs), 0);
        chk("areset div_active", int'(div_active), 326);
        chk("areset upd_pend", int'(upd_pend), 0);
        step();
        reset = 1'b1;
        nxt(0, 1'b1, n);
        chk("post reset first ovs", n, 326);
        chk("post reset div_active", int'(div_active), 326);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule

// File: doc/iiitb_brg_prog.md
Name: iiitb_brg_prog

Overview:
- Programmable, parametrised baud-rate generator; successor to the fixed 4-rate BRG.
- Divides `clk` by a runtime-selectable divisor to produce an oversampling tick, a baud tick and a 50%-duty baud clock `clkout`.
- Divisor comes from four parameter presets selected by `sel`, or from a software-loaded custom register.
- Divisor changes are glitch-free: applied only at baud-period boundaries. Feeds UART TX/RX blocks.

Parameters:
- DIV_W, 16, width of divisor and prescaler counter.
- OVS, 16, oversampling factor. Even, ≥2. Baud period = D*OVS clk cycles.
- DIV0, 326, preset divisor for sel=00.
- DIV1, 163, preset divisor for sel=01.
- DIV2, 81, preset divisor for sel=10.
- DIV3, 27, preset divisor for sel=11.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  generator enable.
- sel  in  2  preset select.
- use_custom  in  1  1 = use custom divisor register instead of preset.
- div_load  in  1  1-cycle strobe; capture `div_in` into custom register.
- div_in  in  DIV_W  custom divisor value.
- tick_ovs  out  1  1-cycle pulse at baud*OVS rate.
- tick_baud  out  1  1-cycle pulse at baud rate.
- clkout  out  1  baud-rate square wave, 50% duty.
- div_active  out  DIV_W  divisor currently in use.
- upd_pend  out  1  requested divisor ≠ active divisor.

Behaviour:
- Reset (reset=0, async):
  - prescaler pcnt=0, oversample counter ocnt=0.
  - tick_ovs=0, tick_baud=0, clkout=0, upd_pend=0.
  - custom register=DIV0, div_active=DIV0.
- Requested divisor R (combinational): use_custom ? custom : DIVsel.
- Effective divisor D = max(div_active, 1); div_active=0 behaves as 1.
- div_load: custom ← div_in at that edge. Visible in R the next cycle.
- Prescaler (en=1):
  - pcnt counts 0..D-1, wraps to 0.
  - tick_ovs registered: high for exactly the cycle after pcnt==D-1 is sampled.
  - Period D cycles; with D=1, tick_ovs is high every cycle.
- Oversample counter:
  - ocnt increments on each tick_ovs event, wrapping OVS-1→0.
  - tick_baud asserts in the same cycle as tick_ovs when ocnt wraps OVS-1→0.
- clkout:
  - Toggles on the tick_ovs event where ocnt goes OVS/2-1→OVS/2 (rises) and on the one where ocnt goes OVS-1→0 (falls).
  - High D*OVS/2 cycles, low D*OVS/2 cycles.
  - Falling edge coincides with tick_baud.
- Divisor commit:
  - While en=1: div_active ← R only on the tick_baud event, so the current baud period always completes with the old divisor.
  - Multiple R changes within one period: only the value present at the boundary is committed.
- upd_pend: registered (R != div_active); clears the cycle after commit.
- en=0 (synchronous):
  - Next edge: pcnt=0, ocnt=0, tick_ovs=0, tick_baud=0, clkout=0.
  - div_active ← R every cycle (immediate update while idle).
- en rising: counting restarts from 0. First tick_ovs D cycles after first enabled edge; first tick_baud D*OVS cycles after.
- Simultaneous events:
  - div_load together with commit boundary: commit uses old R; new custom value commits at the next boundary.
  - en falling on a boundary: idle clear takes priority; ticks not asserted.
- Reset mid-operation: immediate async clear as above; no partial pulses after release. Counting resumes from 0 with div_active=DIV0.
- Widths:
  - pcnt and div_active are DIV_W bits; ocnt is clog2(OVS) bits.
  - Counter compares are unsigned; no overflow because pcnt < D ≤ 2^DIV_W-1.

Test Plan:
- Reset release, en=1, sel=11, use_custom=0 → tick_ovs every 27 cycles; tick_baud every 432; clkout 216 high / 216 low; div_active=27.
- sel 11→00 mid-period → upd_pend=1 until next tick_baud; current period still 432 cycles; following periods 5216 cycles; upd_pend=0 after commit.
- div_in=3, div_load pulse, use_custom=1 while running → period completes with old divisor, then tick_ovs every 3 cycles, tick_baud every 48, clkout 24/24.
- Custom divisor 0 and 1 → tick_ovs high every cycle; tick_baud every OVS=16 cycles; clkout 8/8.
- en dropped mid-period, sel changed, en raised → outputs 0 next cycle; div_active updates immediately; first tick_ovs exactly D cycles after re-enable.
- reset asserted asynchronously between edges mid-period → all outputs 0 immediately; after release with en=1, div_active=326 and first tick_ovs 326 cycles later.
